tone_synth: RTL and testbench

- Multi-channel programmable square-wave tone generator with a duration sequencer and a 1-bit mixed speaker output.
- A controller issues note commands (channel, note, octave, duration) over a valid/ready interface.
- Each channel plays its note for the commanded number of duration ticks, then goes idle.
- Channel waveforms are mixed by a first-order sigma-delta stage to drive a single speaker pin.

---
 rtl/tone_pkg.sv | 48 ++++
 rtl/tone_channel.sv | 128 ++++++++++++
 rtl/tone_synth.sv | 122 ++++++++++++
 tb/tb_tone_synth.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the tone synthesizer: note encoding, base frequency table and half-period math.
// Latency: n/a (compile-time constants and an elaboration-time helper function only).
// Backpressure: n/a.
package tone_pkg;

    // Note encoding on cmd_note; anything at or above NOTE_REST_MIN is a rest.
    localparam logic [3:0] NOTE_A        = 4'd0;
    localparam logic [3:0] NOTE_AS       = 4'd1;
    localparam logic [3:0] NOTE_B        = 4'd2;
    localparam logic [3:0] NOTE_C        = 4'd3;
    localparam logic [3:0] NOTE_CS       = 4'd4;
    localparam logic [3:0] NOTE_D        = 4'd5;
    localparam logic [3:0] NOTE_DS       = 4'd6;
    localparam logic [3:0] NOTE_E        = 4'd7;
    localparam logic [3:0] NOTE_F        = 4'd8;
    localparam logic [3:0] NOTE_FS       = 4'd9;
    localparam logic [3:0] NOTE_G        = 4'd10;
    localparam logic [3:0] NOTE_GS       = 4'd11;
    localparam logic [3:0] NOTE_REST_MIN = 4'd12;

    // Octave-0 note frequencies in millihertz (A = 55 Hz).
    localparam int unsigned F_MHZ [12] = '{
        55000, 58270, 61735, 65406, 69296, 73416,
        77782, 82407, 87307, 92499, 97999, 103826
    };

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_PLAY = 1'b1
    } ch_state_t;

    // Clock cycles per half period, rounded to nearest, shifted down per octave, never below 1.
    // Only ever called with constant arguments so it folds away at elaboration.
    function automatic int unsigned half_period(input longint unsigned clk_hz,
                                                input logic [3:0]      note,
                                                input logic [2:0]      octave);
        longint unsigned f;
        longint unsigned h;
        f = (note < NOTE_REST_MIN) ? 64'(F_MHZ[note]) : 64'(F_MHZ[0]);
        h = (clk_hz * 64'd500 + f / 64'd2) / f;
        h = h >> octave;
        if (h == 64'd0) begin
            h = 64'd1;
        end
        return 32'(h);
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone channel: IDLE/PLAY FSM, half-period counter, duration counter and square-wave register.
// Latency: state loads on the edge after start; first wave toggle one half-period later.
// Backpressure: none here; the parent only asserts start while busy is low. Ports: start/stop/tick
// controls, note/octave/dur command fields, busy and wave outputs.
module tone_channel
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int          DUR_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             tick,
    input  logic [3:0]       note,
    input  logic [2:0]       octave,
    input  logic [DUR_W-1:0] dur,
    output logic             busy,
    output logic             wave
);

    // Note A has the lowest frequency, so its half period sizes the counter.
    localparam int P_W = $clog2(half_period(64'(CLK_HZ), NOTE_A, 3'd0) + 1);

    ch_state_t        state, state_nxt;
    logic [P_W-1:0]   half_cnt, half_nxt;
    logic [P_W-1:0]   half_rld, rld_nxt;
    logic [DUR_W-1:0] dur_cnt, dur_nxt;
    logic             wave_q, wave_nxt;
    logic             rest_q, rest_nxt;

    logic [P_W-1:0]   base;
    logic [P_W-1:0]   shifted;
    logic [P_W-1:0]   eff_m1;

    // Octave-0 half period for the commanded note; rests borrow A's value (it is never audible).
    always_comb begin
        base = P_W'(half_period(64'(CLK_HZ), NOTE_A, 3'd0));
        case (note)
            NOTE_AS: base = P_W'(half_period(64'(CLK_HZ), NOTE_AS, 3'd0));
            NOTE_B:  base = P_W'(half_period(64'(CLK_HZ), NOTE_B,  3'd0));
            NOTE_C:  base = P_W'(half_period(64'(CLK_HZ), NOTE_C,  3'd0));
            NOTE_CS: base = P_W'(half_period(64'(CLK_HZ), NOTE_CS, 3'd0));
            NOTE_D:  base = P_W'(half_period(64'(CLK_HZ), NOTE_D,  3'd0));
            NOTE_DS: base = P_W'(half_period(64'(CLK_HZ), NOTE_DS, 3'd0));
            NOTE_E:  base = P_W'(half_period(64'(CLK_HZ), NOTE_E,  3'd0));
            NOTE_F:  base = P_W'(half_period(64'(CLK_HZ), NOTE_F,  3'd0));
            NOTE_FS: base = P_W'(half_period(64'(CLK_HZ), NOTE_FS, 3'd0));
            NOTE_G:  base = P_W'(half_period(64'(CLK_HZ), NOTE_G,  3'd0));
            NOTE_GS: base = P_W'(half_period(64'(CLK_HZ), NOTE_GS, 3'd0));
            default: ;
        endcase
    end

    // Effective half period is max(1, base >> octave); the counter runs from that minus one down to 0.
    always_comb begin
        shifted = base >> octave;
        eff_m1  = (shifted == '0) ? '0 : shifted - P_W'(1);
    end

    always_comb begin
        state_nxt = state;
        half_nxt  = half_cnt;
        rld_nxt   = half_rld;
        dur_nxt   = dur_cnt;
        wave_nxt  = wave_q;
        rest_nxt  = rest_q;
        if (stop) begin
            state_nxt = CH_IDLE;
            wave_nxt  = 1'b0;
        end else begin
            case (state)
                CH_IDLE: begin
                    if (start) begin
                        state_nxt = CH_PLAY;
                        dur_nxt   = dur;
                        wave_nxt  = 1'b0;
                        half_nxt  = eff_m1;
                        rld_nxt   = eff_m1;
                        rest_nxt  = (note >= NOTE_REST_MIN);
                    end
                end
                CH_PLAY: begin
                    if (tick && (dur_cnt == DUR_W'(1))) begin
                        state_nxt = CH_IDLE;
                        wave_nxt  = 1'b0;
                    end else begin
                        if (tick) begin
                            dur_nxt = dur_cnt - DUR_W'(1);
                        end
                        if (half_cnt == '0) begin
                            half_nxt = half_rld;
                            if (!rest_q) begin
                                wave_nxt = ~wave_q;
                            end
                        end else begin
                            half_nxt = half_cnt - P_W'(1);
                        end
                    end
                end
                default: state_nxt = CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CH_IDLE;
            half_cnt <= '0;
            half_rld <= '0;
            dur_cnt  <= '0;
            wave_q   <= 1'b0;
            rest_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            half_cnt <= half_nxt;
            half_rld <= rld_nxt;
            dur_cnt  <= dur_nxt;
            wave_q   <= wave_nxt;
            rest_q   <= rest_nxt;
        end
    end

    assign busy = (state == CH_PLAY);
    assign wave = wave_q;

endmodule

// File: rtl/tone_synth.sv
// Multi-channel square-wave tone generator with duration sequencing and a sigma-delta 1-bit mixer.
// Latency: command to channel state one edge; ch_wave to speaker one edge.
// Backpressure: cmd_ready drops when the target channel is busy, the channel index is out of range,
// stop_all is high or reset is asserted. Ports: cmd_* command bus, stop_all abort, busy/ch_wave per
// channel, speaker mixed output.
module tone_synth
    import tone_pkg::*;
#(
    parameter  int          NUM_CH  = 2,
    parameter  int unsigned CLK_HZ  = 12000000,
    parameter  int unsigned TICK_HZ = 1000,
    parameter  int          DUR_W   = 16,
    localparam int          CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [3:0]        cmd_note,
    input  logic [2:0]        cmd_octave,
    input  logic [DUR_W-1:0]  cmd_dur,
    input  logic              stop_all,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] ch_wave,
    output logic              speaker
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int          TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Wide enough for e + popcount, which is below 2*NUM_CH.
    localparam int          MIX_W    = $clog2(2 * NUM_CH + 1);

    // ---------------- tick prescaler ----------------
    logic [TW-1:0] pre_cnt;
    logic          tick;

    assign tick = (pre_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + TW'(1);
        end
    end

    // ---------------- command decode ----------------
    logic              sel_busy;
    logic              accept;
    logic [NUM_CH-1:0] start_vec;

    // An index with no matching channel looks permanently busy, so it is never accepted.
    always_comb begin
        sel_busy = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_ch == CH_W'(i)) begin
                sel_busy = busy[i];
            end
        end
    end

    assign cmd_ready = rst_n && !stop_all && !sel_busy;
    assign accept    = cmd_valid && cmd_ready;

    // A zero-duration command completes the handshake but starts nothing.
    always_comb begin
        start_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            start_vec[i] = accept && (cmd_dur != '0) && (cmd_ch == CH_W'(i));
        end
    end

    // ---------------- channels ----------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tone_channel #(
            .CLK_HZ (CLK_HZ),
            .DUR_W  (DUR_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start_vec[g]),
            .stop   (stop_all),
            .tick   (tick),
            .note   (cmd_note),
            .octave (cmd_octave),
            .dur    (cmd_dur),
            .busy   (busy[g]),
            .wave   (ch_wave[g])
        );
    end

    // ---------------- sigma-delta mixer ----------------
    logic [MIX_W-1:0] wave_sum;
    logic [MIX_W-1:0] mix_err;
    logic [MIX_W-1:0] mix_t;

    always_comb begin
        wave_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wave_sum = wave_sum + MIX_W'(ch_wave[i]);
        end
        mix_t = mix_err + wave_sum;
    end

    // Emit a 1 whenever the accumulated level reaches a full-scale unit; keep the remainder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mix_err <= '0;
            speaker <= 1'b0;
        end else if (mix_t >= MIX_W'(NUM_CH)) begin
            mix_err <= mix_t - MIX_W'(NUM_CH);
            speaker <= 1'b1;
        end else begin
            mix_err <= mix_t;
            speaker <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth at CLK_HZ=22000, TICK_HZ=1000 (tick every 22 cycles, HALF[A]=200).
// Inputs change and outputs are sampled 1 ns after the rising edge; cyc counts edges since reset release.
// A second 3-channel instance covers out-of-range channel indices, which a 1-bit cmd_ch cannot encode.
module tb_tone_synth;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [0:0]  cmd_ch;
    logic [3:0]  cmd_note;
    logic [2:0]  cmd_octave;
    logic [15:0] cmd_dur;
    logic        stop_all;
    logic [1:0]  busy;
    logic [1:0]  ch_wave;
    logic        speaker;

    logic        c3_valid;
    logic        c3_ready;
    logic [1:0]  c3_ch;
    logic        c3_stop;
    logic [2:0]  c3_busy;
    logic [2:0]  c3_wave;
    logic        c3_spk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    tone_synth #(.NUM_CH(2), .CLK_HZ(22000), .TICK_HZ(1000), .DUR_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_note(cmd_note), .cmd_octave(cmd_octave), .cmd_dur(cmd_dur),
        .stop_all(stop_all), .busy(busy), .ch_wave(ch_wave), .speaker(speaker)
    );

    tone_synth #(.NUM_CH(3), .CLK_HZ(22000), .TICK_HZ(1000), .DUR_W(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
        .cmd_ch(c3_ch), .cmd_note(cmd_note), .cmd_octave(cmd_octave), .cmd_dur(cmd_dur),
        .stop_all(c3_stop), .busy(c3_busy), .ch_wave(c3_wave), .speaker(c3_spk)
    );

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        stop_all  = 1'b0;
        c3_valid  = 1'b0;
        c3_stop   = 1'b0;
        repeat (3) step;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic issue(input logic [0:0] ch, input logic [3:0] n, input logic [2:0] o,
                         input logic [15:0] d);
        cmd_ch     = ch;
        cmd_note   = n;
        cmd_octave = o;
        cmd_dur    = d;
        cmd_valid  = 1'b1;
        step;
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; stop_all = 1'b0; c3_valid = 1'b0; c3_stop = 1'b0;
        cmd_ch = 1'b0; cmd_note = 4'd0; cmd_octave = 3'd0; cmd_dur = 16'd0; c3_ch = 2'd0;
        repeat (3) step;
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected 00", busy); end
        checks++; if (ch_wave !== 2'b00) begin errors++; $display("FAIL reset_wave: got %b expected 00", ch_wave); end
        checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL reset_speaker: got %b expected 0", speaker); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset: got %b expected 0", cmd_ready); end
        rst_n = 1'b1;
        cyc   = 0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", cmd_ready); end
        // dur=1 accepted on edge 1 ends on the first tick, which lands on edge 22.
        issue(1'b0, 4'd0, 3'd0, 16'd1);
        while (cyc < 21) step;
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL first_tick_pre: busy0=%b expected 1 at cyc %0d", busy[0], cyc); end
        step;
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL first_tick: busy0=%b expected 0 at cyc %0d", busy[0], cyc); end
    endtask

    task automatic test_single_note;
        int fall_k;
        logic exp_b, exp_w;
        fall_k = -1;
        do_reset;
        issue(1'b0, 4'd0, 3'd1, 16'd50);
        for (int k = 1; k <= 1110; k++) begin
            step;
            exp_b = (k < 1099);
            exp_w = exp_b ? 1'((k / 100) % 2) : 1'b0;
            if (busy[0] === 1'b0 && fall_k < 0) fall_k = k;
            checks++; if (busy[0] !== exp_b) begin errors++; $display("FAIL note_busy k=%0d: got %b expected %b", k, busy[0], exp_b); end
            checks++; if (ch_wave[0] !== exp_w) begin errors++; $display("FAIL note_wave k=%0d: got %b expected %b", k, ch_wave[0], exp_w); end
        end
        checks++;
        if (fall_k < 1078 || fall_k > 1100) begin
            errors++; $display("FAIL note_dur_window: fell at %0d expected 1078..1100", fall_k);
        end
    endtask

    task automatic test_handshake;
        logic exp_w;
        do_reset;
        issue(1'b0, 4'd0, 3'd1, 16'd50);
        cmd_ch = 1'b0; #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_busy_ch0: got %b expected 0", cmd_ready); end
        cmd_ch = 1'b1; #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_free_ch1: got %b expected 1", cmd_ready); end
        issue(1'b1, 4'd1, 3'd0, 16'd50);
        for (int k = 1; k <= 400; k++) begin
            step;
            exp_w = 1'((k / 189) % 2);
            checks++; if (ch_wave[1] !== exp_w) begin errors++; $display("FAIL asharp_wave k=%0d: got %b expected %b", k, ch_wave[1], exp_w); end
        end
        cmd_ch = 1'b1; #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_busy_ch1: got %b expected 0", cmd_ready); end
        checks++; if (busy !== 2'b11) begin errors++; $display("FAIL both_busy: got %b expected 11", busy); end
    endtask

    task automatic test_channel_range;
        do_reset;
        c3_ch = 2'd3; #1;
        checks++; if (c3_ready !== 1'b0) begin errors++; $display("FAIL range_ready_ch3: got %b expected 0", c3_ready); end
        c3_ch = 2'd2; #1;
        checks++; if (c3_ready !== 1'b1) begin errors++; $display("FAIL range_ready_ch2: got %b expected 1", c3_ready); end
        cmd_note = 4'd0; cmd_octave = 3'd0; cmd_dur = 16'd5;
        c3_ch = 2'd3; c3_valid = 1'b1; step; c3_valid = 1'b0;
        checks++; if (c3_busy !== 3'b000) begin errors++; $display("FAIL range_no_start: got %b expected 000", c3_busy); end
        c3_ch = 2'd2; c3_valid = 1'b1; step; c3_valid = 1'b0;
        checks++; if (c3_busy !== 3'b100) begin errors++; $display("FAIL range_ch2_start: got %b expected 100", c3_busy); end
    endtask

    task automatic test_mixer;
        logic exp_s;
        // ch0 alone: rises on edge 201, speaker alternates from edge 202.
        do_reset;
        issue(1'b0, 4'd0, 3'd0, 16'd100);
        while (cyc < 209) begin
            step;
            if (cyc >= 150) begin
                exp_s = (cyc >= 202) ? 1'(cyc % 2) : 1'b0;
                checks++; if (speaker !== exp_s) begin errors++; $display("FAIL mix_one cyc=%0d: got %b expected %b", cyc, speaker, exp_s); end
            end
        end
        // Both channels: high together on edges 202..400, low together 402..600.
        do_reset;
        issue(1'b0, 4'd0, 3'd0, 16'd100);
        issue(1'b1, 4'd0, 3'd0, 16'd100);
        while (cyc < 600) begin
            step;
            exp_s = (cyc >= 203 && cyc <= 402);
            checks++; if (speaker !== exp_s) begin errors++; $display("FAIL mix_two cyc=%0d: got %b expected %b", cyc, speaker, exp_s); end
        end
    endtask

    task automatic test_rest_zero;
        logic exp_b;
        do_reset;
        issue(1'b0, 4'd15, 3'd0, 16'd10);
        while (cyc < 225) begin
            step;
            exp_b = (cyc < 220);
            checks++; if (busy[0] !== exp_b) begin errors++; $display("FAIL rest_busy cyc=%0d: got %b expected %b", cyc, busy[0], exp_b); end
            checks++; if (ch_wave[0] !== 1'b0) begin errors++; $display("FAIL rest_wave cyc=%0d: got %b expected 0", cyc, ch_wave[0]); end
        end
        cmd_ch = 1'b1; cmd_note = 4'd0; cmd_octave = 3'd0; cmd_dur = 16'd0; cmd_valid = 1'b1; #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_dur_ready: got %b expected 1", cmd_ready); end
        step; cmd_valid = 1'b0;
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL zero_dur_busy: got %b expected 00", busy); end
        issue(1'b1, 4'd11, 3'd7, 16'd5);
        for (int k = 1; k <= 6; k++) begin
            step;
            checks++; if (ch_wave[1] !== 1'(k % 2)) begin errors++; $display("FAIL oct7_wave k=%0d: got %b expected %0d", k, ch_wave[1], k % 2); end
        end
    endtask

    task automatic test_abort;
        do_reset;
        issue(1'b0, 4'd0, 3'd1, 16'd50);
        issue(1'b1, 4'd11, 3'd7, 16'd50);
        while (cyc < 110) step;
        checks++; if (ch_wave[0] !== 1'b1) begin errors++; $display("FAIL abort_pre_wave: got %b expected 1", ch_wave[0]); end
        stop_all = 1'b1; cmd_ch = 1'b1; #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", cmd_ready); end
        step; stop_all = 1'b0;
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL abort_busy: got %b expected 00", busy); end
        checks++; if (ch_wave !== 2'b00) begin errors++; $display("FAIL abort_wave: got %b expected 00", ch_wave); end
        // ch1 is free, yet a command presented alongside stop_all must not start it.
        issue(1'b0, 4'd0, 3'd1, 16'd50);
        stop_all = 1'b1; cmd_ch = 1'b1; cmd_note = 4'd0; cmd_octave = 3'd0; cmd_dur = 16'd20;
        cmd_valid = 1'b1; #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_free: got %b expected 0", cmd_ready); end
        step; cmd_valid = 1'b0; stop_all = 1'b0;
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL abort_no_accept: got %b expected 00", busy); end
        // Reset in the middle of a note.
        issue(1'b0, 4'd0, 3'd1, 16'd50);
        issue(1'b1, 4'd11, 3'd7, 16'd50);
        repeat (105) step;
        rst_n = 1'b0;
        step;
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL rst_mid_busy: got %b expected 00", busy); end
        checks++; if (ch_wave !== 2'b00) begin errors++; $display("FAIL rst_mid_wave: got %b expected 00", ch_wave); end
        checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL rst_mid_speaker: got %b expected 0", speaker); end
        step;
        checks++; if (ch_wave !== 2'b00) begin errors++; $display("FAIL rst_mid_tail: got %b expected 00", ch_wave); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_single_note;
        test_handshake;
        test_channel_range;
        test_mixer;
        test_rest_zero;
        test_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
